data_ram_bhw: RTL and testbench

Parametrised byte-addressable data RAM for the CPU data path. It supports byte, halfword and word loads and stores, with optional sign extension on loads. It uses a one-cycle req/ack handshake, detects misaligned accesses, and runs an optional clear-on-reset sweep with a busy indication. It replaces the fixed-size load/store memory in the MEM stage.

---
 rtl/data_ram_bhw.sv | 141 ++++++++++++++
 tb/tb_data_ram_bhw.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_bhw.sv
// Byte-addressable data RAM with byte/halfword/word access, a one-cycle req/ack handshake,
// misalignment rejection and an optional zero-fill sweep after reset.
module data_ram_bhw #(
    parameter int ADDR_WIDTH     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            mode,
    input  logic                  uns,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  ack,
    output logic                  misalign,
    output logic                  busy
);

    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IW;
    localparam logic [IW-1:0] CNT_LAST = '1;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t      r_state;
    logic [IW-1:0] r_cnt;
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic        r_ack;
    logic        r_misalign;
    logic        r_busy;

    logic [IW-1:0] w_idx;
    logic          w_misalign;
    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;

    assign w_idx  = addr[ADDR_WIDTH-1:2];
    assign w_word = r_mem[w_idx];

    assign w_misalign = (mode == 2'b11)
                      || ((mode == 2'b01) && addr[0])
                      || ((mode == 2'b10) && (addr[1:0] != 2'b00));

    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = wdata;
        case (mode)
            2'b00: begin
                w_be[addr[1:0]] = 1'b1;
                w_wlanes        = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be     = addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{wdata[15:0]}};
            end
            2'b10: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_byte = w_word[7:0];
        case (addr[1:0])
            2'b00: w_byte = w_word[7:0];
            2'b01: w_byte = w_word[15:8];
            2'b10: w_byte = w_word[23:16];
            2'b11: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
        w_half = addr[1] ? w_word[31:16] : w_word[15:0];
        case (mode)
            2'b00:   w_load = {{24{~uns & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~uns & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Array has no reset of its own; zeroing is done only by the sweep.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else if (req && we && !w_misalign) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            r_busy     <= CLEAR_ON_RESET;
            r_cnt      <= '0;
            r_rdata    <= '0;
            r_ack      <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_ack      <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (req) begin
                        r_ack <= 1'b1;
                        if (w_misalign) begin
                            r_misalign <= 1'b1;
                            r_rdata    <= '0;
                        end else if (!we) begin
                            r_rdata <= w_load;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rdata    = r_rdata;
    assign ack      = r_ack;
    assign misalign = r_misalign;
    assign busy     = r_busy;

endmodule

// File: tb/tb_data_ram_bhw.sv
// Directed plus random checks of data_ram_bhw against a byte-array reference model.
module tb_data_ram_bhw;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        uns = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        misalign;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mm [1024];
    logic [31:0] exp_rdata;

    data_ram_bhw #(.ADDR_WIDTH(10), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .clr(clr), .req(req), .we(we), .mode(mode), .uns(uns),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack),
        .misalign(misalign), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ref_bad(input int md, input int a);
        return (md == 3) || (md == 1 && (a % 2) != 0) || (md == 2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input int md, input bit u, input int a);
        logic [7:0]  b;
        logic [15:0] h;
        if (md == 0) begin
            b = mm[a];
            return u ? {24'h0, b} : {{24{b[7]}}, b};
        end else if (md == 1) begin
            h = {mm[a+1], mm[a]};
            return u ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
    endfunction

    // One access; leaves req high when hold is set so the next call is back-to-back.
    task automatic access(input string tag, input bit w, input int md, input bit u,
                          input int a, input logic [31:0] d, input bit hold);
        int n;
        logic [31:0] v;
        req = 1'b1; we = w; mode = md[1:0]; uns = u; addr = a[9:0]; wdata = d;
        tick();
        if (!hold) req = 1'b0;
        check({tag, ".ack"}, {31'b0, ack}, 32'd1);
        if (ref_bad(md, a)) begin
            exp_rdata = '0;
            check({tag, ".mis"}, {31'b0, misalign}, 32'd1);
        end else begin
            check({tag, ".mis"}, {31'b0, misalign}, 32'd0);
            if (w) begin
                n = (md == 0) ? 1 : (md == 1) ? 2 : 4;
                v = d;
                for (int k = 0; k < n; k++) mm[a+k] = v[8*k +: 8];
            end else begin
                exp_rdata = ref_load(md, u, a);
            end
        end
        check({tag, ".rdata"}, rdata, exp_rdata);
    endtask

    task automatic idle_check(input string tag);
        req = 1'b0;
        tick();
        check({tag, ".ack"}, {31'b0, ack}, 32'd0);
        check({tag, ".hold"}, rdata, exp_rdata);
    endtask

    initial begin
        int n;
        int acks;
        int a, md;
        bit w, u;

        for (int i = 0; i < 1024; i++) mm[i] = 8'h00;
        exp_rdata = '0;

        // Reset and full sweep
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("rst.busy", {31'b0, busy}, 32'd1);
        check("rst.ack", {31'b0, ack}, 32'd0);
        check("rst.mis", {31'b0, misalign}, 32'd0);
        check("rst.rdata", rdata, 32'd0);
        n = 1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (!busy) break;
            n++;
        end
        check("sweep1.len", n, 32'd256);

        access("ld3fc", 1'b0, 2, 1'b0, 'h3FC, 32'h0, 1'b0);

        // Sign extension
        access("st010", 1'b1, 2, 1'b0, 'h010, 32'h800000F1, 1'b0);
        access("lb_s", 1'b0, 0, 1'b0, 'h010, 32'h0, 1'b0);
        check("lb_s.val", rdata, 32'hFFFFFFF1);
        access("lb_u", 1'b0, 0, 1'b1, 'h010, 32'h0, 1'b0);
        check("lb_u.val", rdata, 32'h000000F1);
        access("lh_s", 1'b0, 1, 1'b0, 'h012, 32'h0, 1'b0);
        check("lh_s.val", rdata, 32'hFFFF8000);
        access("lh_u", 1'b0, 1, 1'b1, 'h012, 32'h0, 1'b0);
        check("lh_u.val", rdata, 32'h00008000);

        // Sub-word stores
        access("sw020", 1'b1, 2, 1'b0, 'h020, 32'h11111111, 1'b0);
        access("sb021", 1'b1, 0, 1'b0, 'h021, 32'h000000AB, 1'b0);
        access("sh022", 1'b1, 1, 1'b0, 'h022, 32'h00001234, 1'b0);
        access("lw020", 1'b0, 2, 1'b0, 'h020, 32'h0, 1'b0);
        check("lw020.val", rdata, 32'h1234AB11);
        idle_check("gap1");

        // Misalignment and illegal mode
        access("lw013", 1'b0, 2, 1'b0, 'h013, 32'h0, 1'b0);
        check("lw013.zero", rdata, 32'h0);
        access("sh021", 1'b1, 1, 1'b0, 'h021, 32'hFFFFFFFF, 1'b0);
        access("st_m3", 1'b1, 3, 1'b0, 'h020, 32'hDEADDEAD, 1'b0);
        access("lw020b", 1'b0, 2, 1'b0, 'h020, 32'h0, 1'b0);
        check("lw020b.val", rdata, 32'h1234AB11);
        access("ld_m3", 1'b0, 3, 1'b0, 'h024, 32'h0, 1'b0);

        // Back-to-back
        access("b2b.st", 1'b1, 2, 1'b0, 'h040, 32'hCAFEBABE, 1'b1);
        access("b2b.ld0", 1'b0, 2, 1'b0, 'h040, 32'h0, 1'b1);
        check("b2b.val", rdata, 32'hCAFEBABE);
        access("b2b.ld1", 1'b0, 2, 1'b0, 'h044, 32'h0, 1'b0);
        idle_check("b2b.end");

        // Random traffic with occasional idle cycles
        for (int i = 0; i < 300; i++) begin
            w  = 1'($urandom_range(0, 1));
            md = $urandom_range(0, 3);
            u  = 1'($urandom_range(0, 1));
            a  = (i < 150) ? $urandom_range(0, 63) : $urandom_range(0, 1023);
            access("rnd", w, md, u, a, $urandom, 1'($urandom_range(0, 2) != 0));
            if ($urandom_range(0, 4) == 0) idle_check("rnd.gap");
        end
        idle_check("rnd.end");

        // Reset mid-sweep with a request held through busy
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_rdata = '0;
        req = 1'b1; we = 1'b0; mode = 2'b10; uns = 1'b0; addr = 10'h010; wdata = '0;
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ack) acks++;
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("rst2.busy", {31'b0, busy}, 32'd1);
        n = 1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (ack) acks++;
            if (!busy) break;
            n++;
        end
        check("sweep2.len", n, 32'd256);
        check("sweep2.noack", acks, 32'd0);
        for (int i = 0; i < 1024; i++) mm[i] = 8'h00;
        tick();
        req = 1'b0;
        check("held.ack", {31'b0, ack}, 32'd1);
        check("held.mis", {31'b0, misalign}, 32'd0);
        check("held.rdata", rdata, 32'h0);
        idle_check("held.end");
        access("post.ld020", 1'b0, 2, 1'b0, 'h020, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
